// File: rtl/mem_access_stage_pkg.sv
// rtl/mem_access_stage_pkg.sv - shared types and constants for the MEM pipeline stage
package mem_access_stage_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam int TIMEOUT_DEFAULT = 16;

  typedef struct packed {
    logic        valid;
    logic        reg_wr;
    logic        mem_to_reg;
    logic [4:0]  rw;
    logic [31:0] load_data;
    logic [31:0] alu_out;
  } mem_wb_t;

  localparam int MEM_WB_W = $bits(mem_wb_t);

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/mem_wb_reg.sv
// rtl/mem_wb_reg.sv - MEM/WB pipeline register, falling-edge, load enable, sync reset
module mem_wb_reg
  import mem_access_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [MEM_WB_W-1:0] d,
  output logic [MEM_WB_W-1:0] q
);

  always_ff @(negedge clk) begin
    if (rst)
      q <= '0;
    else if (en)
      q <= d;
  end

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - MEM stage: data-memory handshake, stall, redirect, MEM/WB load
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYC = TIMEOUT_DEFAULT,
  parameter int CNT_W       = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [29:0] Btarg,
  input  logic [29:0] Jtarg,
  input  logic        Zero,
  input  logic        Overflow,
  input  logic [31:0] Addr,
  input  logic [31:0] Di,
  input  logic [4:0]  Rw,
  input  logic        MemWr,
  input  logic        Branch,
  input  logic        Jump,
  input  logic        MemtoReg,
  input  logic        RegWr,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [31:0] dm_wdata,
  input  logic [31:0] dm_rdata,
  input  logic        dm_ack,
  output logic        stall,
  output logic        pc_redirect,
  output logic [29:0] pc_target,
  output logic        wb_valid,
  output logic        wb_RegWr,
  output logic        wb_MemtoReg,
  output logic [4:0]  wb_Rw,
  output logic [31:0] wb_Do,
  output logic [31:0] wb_ALUout,
  output logic        align_err,
  output logic        mem_err
);

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic               mem_access;
  logic               mem_op;
  logic               misal;
  logic               timeout;
  mem_wb_t            wb_next;
  mem_wb_t            wb_q;

  assign mem_access = ex_valid & (MemWr | MemtoReg);
  assign mem_op     = mem_access & word_aligned(Addr);
  assign misal      = mem_access & ~word_aligned(Addr);
  assign timeout    = (state == WAIT) & ~dm_ack & (cnt == CNT_W'(TIMEOUT_CYC - 1));

  // A timed-out access retires like an acked one, so EX/MEM must advance too.
  assign stall       = (state == IDLE) ? mem_op : ~(dm_ack | timeout);
  assign pc_redirect = ex_valid & ~stall & (Jump | (Branch & Zero));
  assign pc_target   = Jump ? Jtarg : Btarg;

  always_comb begin
    wb_next            = '0;
    wb_next.valid      = ex_valid;
    wb_next.reg_wr     = ex_valid & RegWr & ~Overflow & ~misal & ~timeout;
    wb_next.mem_to_reg = MemtoReg;
    wb_next.rw         = Rw;
    wb_next.load_data  = ((state == WAIT) && dm_ack && MemtoReg) ? dm_rdata : 32'h0;
    wb_next.alu_out    = Addr;
  end

  mem_wb_reg u_mem_wb (
    .clk (clk),
    .rst (rst),
    .en  (~stall),
    .d   (wb_next),
    .q   (wb_q)
  );

  assign wb_valid    = wb_q.valid;
  assign wb_RegWr    = wb_q.reg_wr;
  assign wb_MemtoReg = wb_q.mem_to_reg;
  assign wb_Rw       = wb_q.rw;
  assign wb_Do       = wb_q.load_data;
  assign wb_ALUout   = wb_q.alu_out;

  always_ff @(negedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      dm_req    <= 1'b0;
      dm_we     <= 1'b0;
      dm_addr   <= 32'h0;
      dm_wdata  <= 32'h0;
      align_err <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      align_err <= 1'b0;
      mem_err   <= 1'b0;
      if (state == IDLE) begin
        align_err <= misal;
        if (mem_op) begin
          state    <= WAIT;
          cnt      <= '0;
          dm_req   <= 1'b1;
          dm_we    <= MemWr;
          dm_addr  <= {Addr[31:2], 2'b00};
          dm_wdata <= Di;
        end
      end else begin
        if (dm_ack || timeout) begin
          state   <= IDLE;
          cnt     <= '0;
          dm_req  <= 1'b0;
          mem_err <= timeout;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

endmodule
